// File: rtl/simd_sub_pipe.sv
// Two-stage pipelined SIMD subtractor (a - b - bin per lane, lanes 4x8 / 2x16 / 1x32).
// Optional macro SIMD_SUB_SAT_EN: lanes that borrow out saturate to zero.
module simd_sub_pipe #(
    parameter int W = 32,
    localparam int NCH = W / 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           bin,
    input  logic [1:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic [NCH-1:0] borrow
);

    logic                  s2_adv;
    logic                  s1_adv;
    logic                  accept;

    logic                  s1_valid_q, s1_valid_d;
    logic [NCH-1:0][8:0]   s1_d0_q, s1_d0_d;
    logic [NCH-1:0][8:0]   s1_d1_q, s1_d1_d;
    logic [1:0]            s1_mode_q, s1_mode_d;
    logic                  s1_bin_q, s1_bin_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [W-1:0]          s2_result_q, s2_result_d;
    logic [NCH-1:0]        s2_borrow_q, s2_borrow_d;

    logic                  is8;
    logic                  is16;
    logic                  chain;
    logic [8:0]            sel;
    logic [NCH-1:0]        lane_lsb;
    logic [NCH-1:0]        lane_top;
    logic [NCH-1:0]        bout;
    logic [W-1:0]          diff;
    logic [NCH-1:0]        bor_vis;
`ifdef SIMD_SUB_SAT_EN
    int                    sat_top;
`endif

    // Stage-wise flow control: a stage may load when it is empty or its consumer moves.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv && rst_n;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d0_d    = s1_d0_q;
        s1_d1_d    = s1_d1_q;
        s1_mode_d  = s1_mode_q;
        s1_bin_d   = s1_bin_q;
        if (s1_adv) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            for (int i = 0; i < NCH; i++) begin
                s1_d0_d[i] = {1'b0, a[8*i +: 8]} - {1'b0, b[8*i +: 8]};
                s1_d1_d[i] = s1_d0_d[i] - 9'd1;
            end
            s1_mode_d = mode;
            s1_bin_d  = bin;
        end
    end

    // Borrow ripple across chunks; lane LSB chunks restart the chain from bin.
    always_comb begin
        is8      = (s1_mode_q == 2'b00);
        is16     = (s1_mode_q == 2'b01);
        chain    = s1_bin_q;
        sel      = '0;
        lane_lsb = '0;
        lane_top = '0;
        bout     = '0;
        diff     = '0;
        for (int i = 0; i < NCH; i++) begin
            lane_lsb[i] = is8 || (is16 && (i % 2 == 0)) || (i == 0);
            lane_top[i] = is8 || (is16 && (i % 2 == 1)) || (i == NCH - 1);
            if (lane_lsb[i]) begin
                chain = s1_bin_q;
            end
            sel            = chain ? s1_d1_q[i] : s1_d0_q[i];
            diff[8*i +: 8] = sel[7:0];
            bout[i]        = sel[8];
            chain          = sel[8];
        end
        bor_vis = bout & lane_top;
`ifdef SIMD_SUB_SAT_EN
        sat_top = 0;
        for (int i = 0; i < NCH; i++) begin
            sat_top = is8 ? i : (is16 ? (i | 1) : NCH - 1);
            if (bout[sat_top]) begin
                diff[8*i +: 8] = '0;
            end
        end
`endif
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_borrow_d = s2_borrow_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = diff;
                s2_borrow_d = bor_vis;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_d0_q     <= '0;
            s1_d1_q     <= '0;
            s1_mode_q   <= 2'b00;
            s1_bin_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_borrow_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_d0_q     <= s1_d0_d;
            s1_d1_q     <= s1_d1_d;
            s1_mode_q   <= s1_mode_d;
            s1_bin_q    <= s1_bin_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_borrow_q <= s2_borrow_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign borrow    = s2_borrow_q;

endmodule

// File: tb/tb_simd_sub_pipe.sv
// Scoreboard bench for simd_sub_pipe: directed vectors, stall/reset cases, random handshake run.
module tb_simd_sub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  borrow;

    int errors = 0;
    int checks = 0;
    logic [35:0] sb_q[$];
    bit rnd_on;

    simd_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: whole-lane arithmetic, independent of chunking.
    function automatic logic [35:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input logic bi, input logic [1:0] m);
        int lw;
        int nl;
        longint unsigned mask;
        longint unsigned x;
        longint unsigned y;
        longint unsigned d;
        logic [31:0] r;
        logic [3:0]  bo;
        bit bw;
        lw = (m == 2'b00) ? 8 : ((m == 2'b01) ? 16 : 32);
        nl = 32 / lw;
        mask = (64'd1 << lw) - 64'd1;
        r = '0;
        bo = '0;
        for (int l = 0; l < nl; l++) begin
            x = (64'(av) >> (l * lw)) & mask;
            y = (64'(bv) >> (l * lw)) & mask;
            d = x - y - 64'(bi);
            bw = (x < y + 64'(bi));
`ifdef SIMD_SUB_SAT_EN
            if (bw) d = 0;
`endif
            r = r | 32'((d & mask) << (l * lw));
            if (bw) bo[(l * lw + lw) / 8 - 1] = 1'b1;
        end
        return {r, bo};
    endfunction

    task automatic send(input logic [31:0] a_i, input logic [31:0] b_i, input logic bin_i,
                        input logic [1:0] m_i, input logic [35:0] exp);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        a = a_i;
        b = b_i;
        bin = bin_i;
        mode = m_i;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(exp);
                done = 1;
            end else if (n > 500) begin
                chk("send_timeout", 1, 0);
                done = 1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        bin = 1'($urandom);
        mode = 2'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", sb_q.size(), 0);
    endtask

    // Monitor: pops on every output transfer, also checks outputs hold while stalled.
    initial begin
        logic [35:0] exp;
        logic [35:0] held;
        bit prev_stall;
        prev_stall = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) chk("hold_stable", {out_valid, result, borrow}, {1'b1, held});
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", {result, borrow}, 36'h0);
                        chk("unexpected_output_valid", 1, 0);
                    end else begin
                        exp = sb_q.pop_front();
                        chk("result", result, exp[35:4]);
                        chk("borrow", borrow, exp[3:0]);
                    end
                end
                prev_stall = out_valid && !out_ready;
                held = {result, borrow};
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rbi;
        logic [1:0]  rm;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        mode = 2'b00;
        out_ready = 1'b1;
        rnd_on = 0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_borrow", borrow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Test 1 with latency check
        send(32'h10203040, 32'h01020304, 1'b0, 2'b00, {32'h0F1E2D3C, 4'b0000});
        @(negedge clk);
        chk("lat1_cycle1", out_valid, 0);
        @(negedge clk);
        chk("lat1_cycle2", out_valid, 1);
        wait_drain();

`ifdef SIMD_SUB_SAT_EN
        send(32'h00000000, 32'h01010101, 1'b0, 2'b00, {32'h00000000, 4'b1111});
        send(32'h00000000, 32'h00000001, 1'b1, 2'b10, {32'h00000000, 4'b1000});
        send(32'h00000000, 32'h00000001, 1'b1, 2'b11, {32'h00000000, 4'b1000});
        send(32'h05050505, 32'h05050505, 1'b1, 2'b00, {32'h00000000, 4'b1111});
        send(32'h0000FFFF, 32'h0000FFFF, 1'b1, 2'b01, {32'h00000000, 4'b1010});
`else
        send(32'h00000000, 32'h01010101, 1'b0, 2'b00, {32'hFFFFFFFF, 4'b1111});
        send(32'h00000000, 32'h00000001, 1'b1, 2'b10, {32'hFFFFFFFE, 4'b1000});
        send(32'h00000000, 32'h00000001, 1'b1, 2'b11, {32'hFFFFFFFE, 4'b1000});
        send(32'h05050505, 32'h05050505, 1'b1, 2'b00, {32'hFFFFFFFF, 4'b1111});
        send(32'h0000FFFF, 32'h0000FFFF, 1'b1, 2'b01, {32'hFFFFFFFF, 4'b1010});
`endif
        send(32'h01000100, 32'h00010001, 1'b0, 2'b01, {32'h00FF00FF, 4'b0000});
        send(32'h12345678, 32'h02040608, 1'b1, 2'b01, {32'h102F506F, 4'b0000});
        wait_drain();

        // Test 5: stall fills two stages, then burst release
        out_ready = 1'b0;
        send(32'h80808080, 32'h01010101, 1'b0, 2'b00, {32'h7F7F7F7F, 4'b0000});
`ifdef SIMD_SUB_SAT_EN
        send(32'h00020001, 32'h00010002, 1'b0, 2'b01, {32'h00010000, 4'b0010});
`else
        send(32'h00020001, 32'h00010002, 1'b0, 2'b01, {32'h0001FFFF, 4'b0010});
`endif
        fork
            send(32'hFFFFFFFF, 32'h00000001, 1'b1, 2'b10, {32'hFFFFFFFD, 4'b0000});
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                end
                chk("stall_accepted", sb_q.size(), 2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("burst_out_valid", out_valid, 1);
                end
            end
        join
        wait_drain();

        // Test 6: reset with both stages full
        out_ready = 1'b0;
        send(32'h11111111, 32'h01010101, 1'b0, 2'b00, {32'h10101010, 4'b0000});
        send(32'h22222222, 32'h01010101, 1'b0, 2'b00, {32'h21212121, 4'b0000});
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_result", result, 0);
        chk("flush_borrow", borrow, 0);
        chk("flush_in_ready", in_ready, 1);
        sb_q.delete();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h10203040, 32'h01020304, 1'b0, 2'b00, {32'h0F1E2D3C, 4'b0000});
        @(negedge clk);
        chk("lat6_cycle1", out_valid, 0);
        @(negedge clk);
        chk("lat6_cycle2", out_valid, 1);
        wait_drain();

        // Random handshake run against the reference model
        rnd_on = 1;
        fork
            begin
                for (int t = 0; t < 1000; t++) begin
                    ra = $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                    rbi = 1'($urandom);
                    rm = 2'($urandom);
                    send(ra, rb, rbi, rm, model(ra, rb, rbi, rm));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
